// File: rtl/tl_master_arbiter_if.sv
// tl_master_arbiter_if
//   One TileLink-UL link (A request channel + D response channel) with a
//   parameterised source width.  The requester side uses modport master;
//   the responder side uses modport slave.
//   Parameter : SRC_W - width of a_source / d_source
//   A channel : a_ready, a_valid, a_opcode[2:0], a_param[2:0], a_size[3:0],
//               a_source, a_address[31:0], a_mask[7:0], a_data[63:0], a_corrupt
//   D channel : d_ready, d_valid, d_opcode[2:0], d_param[1:0], d_size[3:0],
//               d_source, d_sink, d_denied, d_data[63:0], d_corrupt
interface tl_master_arbiter_if #(
  parameter int SRC_W = 1
);
  logic             a_ready;
  logic             a_valid;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [3:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [7:0]       a_mask;
  logic [63:0]      a_data;
  logic             a_corrupt;

  logic             d_ready;
  logic             d_valid;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [3:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_sink;
  logic             d_denied;
  logic [63:0]      d_data;
  logic             d_corrupt;

  modport master (
    input  a_ready,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output d_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
  );

  modport slave (
    output a_ready,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  d_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_master_arbiter.sv
// tl_master_arbiter
//   Two-requester TileLink-UL A-channel arbiter with D-channel response
//   routing.  The downstream source is {requester, upstream source}; the
//   D response is steered back by d_source[1].  Each requester may have at
//   most MAX_INFLIGHT outstanding A requests.
//   Optional feature: define TL_ARB_ROUND_ROBIN_EN for round-robin
//   arbitration; otherwise requester 0 has fixed priority.
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous, active-high
//   r0, r1     - upstream requester links (slave modport, 1-bit source)
//   tl_master  - downstream link (master modport, 2-bit source)
module tl_master_arbiter #(
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_master_arbiter_if.slave   r0,
  tl_master_arbiter_if.slave   r1,
  tl_master_arbiter_if.master  tl_master
);

  localparam logic [2:0] LP_MAX_INFLIGHT = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_inflight0;
  logic [2:0] r_inflight1;

  logic       w_elig0;
  logic       w_elig1;
  logic       w_pick1;
  logic       w_granted;
  logic       w_sel1;
  logic       w_a_valid;
  logic       w_a_fire;
  logic       w_d_sel1;
  logic       w_d_ready;
  logic       w_d_fire;
  logic [3:0] w_a_size;
  logic       w_a_corrupt;

  // A response for a requester with nothing outstanding is still forwarded,
  // but must not wrap the counter; only a "real" decrement cancels an increment.
  function automatic logic [2:0] f_next_inflight(input logic [2:0] cnt,
                                                 input logic       inc,
                                                 input logic       dec);
    logic       dec_eff;
    logic [2:0] nxt;
    dec_eff = dec && (cnt != 3'd0);
    nxt     = cnt;
    if (inc && !dec_eff)      nxt = cnt + 3'd1;
    else if (dec_eff && !inc) nxt = cnt - 3'd1;
    return nxt;
  endfunction

  assign w_elig0 = r0.a_valid && (r_inflight0 < LP_MAX_INFLIGHT);
  assign w_elig1 = r1.a_valid && (r_inflight1 < LP_MAX_INFLIGHT);

`ifdef TL_ARB_ROUND_ROBIN_EN
  // r_rr names the preferred requester; it flips to the other one on each grant.
  logic r_rr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_rr <= 1'b0;
    else if (w_a_fire) r_rr <= ~w_sel1;
  end

  assign w_pick1 = w_elig1 && (!w_elig0 || r_rr);
`else
  assign w_pick1 = w_elig1 && !w_elig0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_inflight0 <= 3'd0;
      r_inflight1 <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_inflight0 <= f_next_inflight(r_inflight0, w_a_fire && !w_sel1, w_d_fire && !w_d_sel1);
      r_inflight1 <= f_next_inflight(r_inflight1, w_a_fire &&  w_sel1, w_d_fire &&  w_d_sel1);
    end
  end

  // The grant is held until the A beat fires so the downstream payload stays stable.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:           if (w_elig0 || w_elig1) w_state_nxt = w_pick1 ? GRANT1 : GRANT0;
      GRANT0, GRANT1: if (w_a_fire) w_state_nxt = IDLE;
      default:        w_state_nxt = IDLE;
    endcase
  end

  assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_sel1    = (r_state == GRANT1);
  assign w_a_valid = w_granted && (w_sel1 ? r1.a_valid : r0.a_valid);
  assign w_a_fire  = w_a_valid && tl_master.a_ready;

  assign r0.a_ready = tl_master.a_ready && (r_state == GRANT0);
  assign r1.a_ready = tl_master.a_ready && (r_state == GRANT1);

  // Only single-beat transfers are supported; larger sizes are passed but flagged corrupt.
  assign w_a_size    = w_sel1 ? r1.a_size : r0.a_size;
  assign w_a_corrupt = (w_sel1 ? r1.a_corrupt : r0.a_corrupt) || (w_a_size > 4'd3);

  assign tl_master.a_valid   = w_a_valid;
  assign tl_master.a_opcode  = w_sel1 ? r1.a_opcode  : r0.a_opcode;
  assign tl_master.a_param   = w_sel1 ? r1.a_param   : r0.a_param;
  assign tl_master.a_size    = w_a_size;
  assign tl_master.a_source  = {w_sel1, (w_sel1 ? r1.a_source : r0.a_source)};
  assign tl_master.a_address = w_sel1 ? r1.a_address : r0.a_address;
  assign tl_master.a_mask    = w_sel1 ? r1.a_mask    : r0.a_mask;
  assign tl_master.a_data    = w_sel1 ? r1.a_data    : r0.a_data;
  assign tl_master.a_corrupt = w_a_corrupt;

  // D path is purely combinational and independent of the A grant; reset
  // masks the handshakes because the inputs are not under our control.
  assign w_d_sel1  = tl_master.d_source[1];
  assign w_d_ready = (w_d_sel1 ? r1.d_ready : r0.d_ready) && !reset;
  assign w_d_fire  = tl_master.d_valid && w_d_ready;

  assign tl_master.d_ready = w_d_ready;

  assign r0.d_valid   = tl_master.d_valid && !w_d_sel1 && !reset;
  assign r0.d_opcode  = tl_master.d_opcode;
  assign r0.d_param   = tl_master.d_param;
  assign r0.d_size    = tl_master.d_size;
  assign r0.d_source  = tl_master.d_source[0];
  assign r0.d_sink    = tl_master.d_sink;
  assign r0.d_denied  = tl_master.d_denied;
  assign r0.d_data    = tl_master.d_data;
  assign r0.d_corrupt = tl_master.d_corrupt;

  assign r1.d_valid   = tl_master.d_valid && w_d_sel1 && !reset;
  assign r1.d_opcode  = tl_master.d_opcode;
  assign r1.d_param   = tl_master.d_param;
  assign r1.d_size    = tl_master.d_size;
  assign r1.d_source  = tl_master.d_source[0];
  assign r1.d_sink    = tl_master.d_sink;
  assign r1.d_denied  = tl_master.d_denied;
  assign r1.d_data    = tl_master.d_data;
  assign r1.d_corrupt = tl_master.d_corrupt;

endmodule

// File: tb/tb_tl_master_arbiter.sv
// tb_tl_master_arbiter
//   Self-checking bench for tl_master_arbiter (MAX_INFLIGHT=2).  The bench
//   plays both requesters and the downstream slave.  Expected downstream A
//   beats are queued in sb_q as requests are driven; observed beats are
//   queued in got_q at each A fire and compared in order.
`timescale 1ns/1ps
module tb_tl_master_arbiter;

  typedef logic [116:0] a_pkt_t;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  int     checks = 0;
  int     errors = 0;
  int     last_fire_n = 1;
  a_pkt_t sb_q[$];
  a_pkt_t got_q[$];

  always #5 clock = ~clock;

  tl_master_arbiter_if #(.SRC_W(1)) u_r0 ();
  tl_master_arbiter_if #(.SRC_W(1)) u_r1 ();
  tl_master_arbiter_if #(.SRC_W(2)) u_dn ();

  tl_master_arbiter #(.MAX_INFLIGHT(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .r0        (u_r0),
    .r1        (u_r1),
    .tl_master (u_dn)
  );

  function automatic a_pkt_t exp_a(input int n, input logic src, input logic [31:0] addr,
                                   input logic [63:0] data, input logic [3:0] size, input logic corrupt);
    logic [1:0] s;
    s = {n[0], src};
    return {s, 3'd4, 3'd0, size, addr, 8'hFF, data, (corrupt || (size > 4'd3))};
  endfunction

  function automatic a_pkt_t seen_a();
    return {u_dn.a_source, u_dn.a_opcode, u_dn.a_param, u_dn.a_size, u_dn.a_address,
            u_dn.a_mask, u_dn.a_data, u_dn.a_corrupt};
  endfunction

  task automatic set_a(input int n, input logic v, input logic src, input logic [31:0] addr,
                       input logic [63:0] data, input logic [3:0] size, input logic corrupt);
    if (n == 0) begin
      u_r0.a_valid = v; u_r0.a_opcode = 3'd4; u_r0.a_param = 3'd0; u_r0.a_size = size;
      u_r0.a_source = src; u_r0.a_address = addr; u_r0.a_mask = 8'hFF; u_r0.a_data = data;
      u_r0.a_corrupt = corrupt;
    end else begin
      u_r1.a_valid = v; u_r1.a_opcode = 3'd4; u_r1.a_param = 3'd0; u_r1.a_size = size;
      u_r1.a_source = src; u_r1.a_address = addr; u_r1.a_mask = 8'hFF; u_r1.a_data = data;
      u_r1.a_corrupt = corrupt;
    end
  endtask

  // Hold a request until it fires or the cycle budget runs out; log the downstream beat.
  task automatic issue(input int n, input logic src, input logic [31:0] addr, input logic [63:0] data,
                       input logic [3:0] size, input logic corrupt, input int budget,
                       output bit fired, output int cycles);
    fired  = 1'b0;
    cycles = 0;
    set_a(n, 1'b1, src, addr, data, size, corrupt);
    while (!fired && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if ((n == 0 ? u_r0.a_ready : u_r1.a_ready) && u_dn.a_valid) begin
        fired = 1'b1;
        got_q.push_back(seen_a());
        last_fire_n = n;
      end
    end
    @(posedge clock); #1;
    set_a(n, 1'b0, src, addr, data, size, corrupt);
  endtask

  task automatic ret_d(input logic [1:0] src, input logic [63:0] data, output bit ok);
    u_dn.d_valid = 1'b1; u_dn.d_source = src; u_dn.d_data = data; u_dn.d_opcode = 3'd1;
    @(negedge clock);
    ok = u_dn.d_ready && (src[1] ? u_r1.d_valid : u_r0.d_valid) &&
         ((src[1] ? u_r1.d_data : u_r0.d_data) == data) &&
         ((src[1] ? u_r1.d_source : u_r0.d_source) == src[0]);
    @(posedge clock); #1;
    u_dn.d_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_r0.a_valid = 1'b1; u_r1.a_valid = 1'b1; u_dn.a_ready = 1'b1;
    u_dn.d_valid = 1'b1; u_dn.d_source = 2'b00;
    repeat (2) @(negedge clock);
    checks++; if (u_r0.a_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_a_ready: got %b want 0", u_r0.a_ready); end
    checks++; if (u_r1.a_ready !== 1'b0) begin errors++; $display("FAIL reset_r1_a_ready: got %b want 0", u_r1.a_ready); end
    checks++; if (u_dn.a_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_a_valid: got %b want 0", u_dn.a_valid); end
    checks++; if (u_r0.d_valid !== 1'b0) begin errors++; $display("FAIL reset_r0_d_valid: got %b want 0", u_r0.d_valid); end
    checks++; if (u_dn.d_ready !== 1'b0) begin errors++; $display("FAIL reset_dn_d_ready: got %b want 0", u_dn.d_ready); end
    u_r0.a_valid = 1'b0; u_r1.a_valid = 1'b0; u_dn.d_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit f, ok; int c; a_pkt_t e, g;
    sb_q.push_back(exp_a(0, 1'b0, 32'h0000_1000, 64'h1111_2222_3333_4444, 4'd3, 1'b0));
    issue(0, 1'b0, 32'h0000_1000, 64'h1111_2222_3333_4444, 4'd3, 1'b0, 10, f, c);
    checks++; if (!f) begin errors++; $display("FAIL single_fire: got %b want 1", f); end
    checks++; if (c != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", c); end
    e = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    checks++; if (g !== e) begin errors++; $display("FAIL single_pkt: got %h want %h", g, e); end
    ret_d(2'b00, 64'h0000_0000_0000_00A0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_d_return: got %b want 1", ok); end
  endtask

  task automatic test_corrupt();
    bit f, ok; int c; a_pkt_t e, g;
    sb_q.push_back(exp_a(1, 1'b1, 32'h0000_2000, 64'h5555_6666_7777_8888, 4'd5, 1'b0));
    issue(1, 1'b1, 32'h0000_2000, 64'h5555_6666_7777_8888, 4'd5, 1'b0, 10, f, c);
    e = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    checks++; if (g !== e) begin errors++; $display("FAIL corrupt_pkt: got %h want %h", g, e); end
    ret_d(2'b11, 64'h0000_0000_0000_00B1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL corrupt_d_return: got %b want 1", ok); end
  endtask

  task automatic test_d_routing();
    u_r1.d_ready = 1'b0; u_r0.d_ready = 1'b1;
    u_dn.d_valid = 1'b1; u_dn.d_source = 2'b11; u_dn.d_data = 64'hDEAD_BEEF_0000_0003; u_dn.d_denied = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (u_r1.d_valid !== 1'b1) begin errors++; $display("FAIL droute_r1_valid: got %b want 1", u_r1.d_valid); end
      checks++; if (u_dn.d_ready !== 1'b0) begin errors++; $display("FAIL droute_dn_ready: got %b want 0", u_dn.d_ready); end
      checks++; if (u_r0.d_valid !== 1'b0) begin errors++; $display("FAIL droute_r0_valid: got %b want 0", u_r0.d_valid); end
    end
    checks++;
    if ({u_r1.d_data, u_r1.d_source, u_r1.d_denied} !== {64'hDEAD_BEEF_0000_0003, 1'b1, 1'b1}) begin
      errors++; $display("FAIL droute_bits: got %h/%b/%b want deadbeef00000003/1/1", u_r1.d_data, u_r1.d_source, u_r1.d_denied);
    end
    @(posedge clock); #1;
    u_r1.d_ready = 1'b1;
    @(negedge clock);
    checks++; if (u_dn.d_ready !== 1'b1) begin errors++; $display("FAIL droute_release: got %b want 1", u_dn.d_ready); end
    @(posedge clock); #1;
    u_dn.d_valid = 1'b0; u_dn.d_denied = 1'b0;
  endtask

  task automatic test_inflight_limit();
    bit f, f0, f1, ok; int c, c0, c1; a_pkt_t e, g;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(exp_a(1, 1'b0, 32'h0000_3000 + 32'(i), 64'h0000_0000_0000_3000 + 64'(i), 4'd3, 1'b0));
      issue(1, 1'b0, 32'h0000_3000 + 32'(i), 64'h0000_0000_0000_3000 + 64'(i), 4'd3, 1'b0, 10, f, c);
      e = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++; if (g !== e) begin errors++; $display("FAIL limit_r1_pkt%0d: got %h want %h", i, g, e); end
    end
    sb_q.push_back(exp_a(0, 1'b0, 32'h0000_3100, 64'h0000_0000_0000_3100, 4'd2, 1'b0));
    fork
      issue(1, 1'b0, 32'h0000_3002, 64'h0000_0000_0000_3002, 4'd3, 1'b0, 12, f1, c1);
      issue(0, 1'b0, 32'h0000_3100, 64'h0000_0000_0000_3100, 4'd2, 1'b0, 12, f0, c0);
    join
    checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL limit_r1_third_blocked: got %b want 0", f1); end
    checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL limit_r0_granted: got %b want 1", f0); end
    e = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    checks++; if (g !== e) begin errors++; $display("FAIL limit_r0_pkt: got %h want %h", g, e); end
    ret_d(2'b10, 64'h1, ok); ret_d(2'b10, 64'h2, ok); ret_d(2'b00, 64'h3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL limit_d_return: got %b want 1", ok); end
  endtask

  task automatic test_same_cycle();
    bit f, ok; int c; bit hit;
    issue(0, 1'b0, 32'h0000_4000, 64'h4000, 4'd3, 1'b0, 10, f, c);
    hit = 1'b0;
    fork
      issue(0, 1'b0, 32'h0000_4001, 64'h4001, 4'd3, 1'b0, 10, f, c);
      begin
        for (int i = 0; i < 10 && !hit; i++) begin
          @(negedge clock);
          if (u_r0.a_ready && u_dn.a_valid) begin
            hit = 1'b1; u_dn.d_valid = 1'b1; u_dn.d_source = 2'b00; u_dn.d_data = 64'h4444;
          end
        end
        @(posedge clock); #1;
        u_dn.d_valid = 1'b0;
      end
    join
    checks++; if (!hit) begin errors++; $display("FAIL same_cycle_overlap: got %b want 1", hit); end
    issue(0, 1'b0, 32'h0000_4002, 64'h4002, 4'd3, 1'b0, 10, f, c);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL same_cycle_second_slot: got %b want 1", f); end
    issue(0, 1'b0, 32'h0000_4003, 64'h4003, 4'd3, 1'b0, 8, f, c);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL same_cycle_full: got %b want 0", f); end
    ret_d(2'b00, 64'h5, ok); ret_d(2'b00, 64'h6, ok);
    got_q.delete();
  endtask

  task automatic test_stall();
    bit f0, f1, ok; int c0, c1, pref; a_pkt_t e0, e1, ef, g;
`ifdef TL_ARB_ROUND_ROBIN_EN
    pref = 1 - last_fire_n;
`else
    pref = 0;
`endif
    e0 = exp_a(0, 1'b1, 32'h0000_5000, 64'hAAAA_0000_0000_5000, 4'd3, 1'b0);
    e1 = exp_a(1, 1'b0, 32'h0000_5100, 64'hBBBB_0000_0000_5100, 4'd2, 1'b0);
    ef = (pref == 0) ? e0 : e1;
    sb_q.push_back(ef);
    sb_q.push_back((pref == 0) ? e1 : e0);
    u_dn.a_ready = 1'b0;
    fork
      issue(0, 1'b1, 32'h0000_5000, 64'hAAAA_0000_0000_5000, 4'd3, 1'b0, 30, f0, c0);
      issue(1, 1'b0, 32'h0000_5100, 64'hBBBB_0000_0000_5100, 4'd2, 1'b0, 30, f1, c1);
      begin
        @(negedge clock);
        repeat (4) begin
          @(negedge clock);
          checks++; if (u_dn.a_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", u_dn.a_valid); end
          checks++; if (seen_a() !== ef) begin errors++; $display("FAIL stall_hold: got %h want %h", seen_a(), ef); end
          checks++; if ({u_r0.a_ready, u_r1.a_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready: got %b want 00", {u_r0.a_ready, u_r1.a_ready}); end
        end
        @(posedge clock); #1;
        u_dn.a_ready = 1'b1;
      end
    join
    for (int i = 0; i < 2; i++) begin
      e0 = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++; if (g !== e0) begin errors++; $display("FAIL stall_pkt%0d: got %h want %h", i, g, e0); end
    end
    ret_d(2'b00, 64'h7, ok); ret_d(2'b10, 64'h8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_d_return: got %b want 1", ok); end
  endtask

  task automatic test_back_to_back();
    bit fa, fb, fc, fd, ok; int ca, cb, cc, cd, pref; a_pkt_t e0a, e0b, e1a, e1b, e, g;
    pref = 1 - last_fire_n;
    e0a = exp_a(0, 1'b0, 32'h0000_6000, 64'h6000, 4'd3, 1'b0);
    e0b = exp_a(0, 1'b0, 32'h0000_6001, 64'h6001, 4'd3, 1'b0);
    e1a = exp_a(1, 1'b0, 32'h0000_6100, 64'h6100, 4'd3, 1'b0);
    e1b = exp_a(1, 1'b0, 32'h0000_6101, 64'h6101, 4'd3, 1'b0);
`ifdef TL_ARB_ROUND_ROBIN_EN
    if (pref == 0) begin sb_q.push_back(e0a); sb_q.push_back(e1a); sb_q.push_back(e0b); sb_q.push_back(e1b); end
    else begin sb_q.push_back(e1a); sb_q.push_back(e0a); sb_q.push_back(e1b); sb_q.push_back(e0b); end
`else
    sb_q.push_back(e0a); sb_q.push_back(e0b); sb_q.push_back(e1a); sb_q.push_back(e1b);
`endif
    u_dn.a_ready = 1'b1;
    fork
      begin
        issue(0, 1'b0, 32'h0000_6000, 64'h6000, 4'd3, 1'b0, 20, fa, ca);
        issue(0, 1'b0, 32'h0000_6001, 64'h6001, 4'd3, 1'b0, 20, fb, cb);
      end
      begin
        issue(1, 1'b0, 32'h0000_6100, 64'h6100, 4'd3, 1'b0, 20, fc, cc);
        issue(1, 1'b0, 32'h0000_6101, 64'h6101, 4'd3, 1'b0, 20, fd, cd);
      end
    join
    for (int i = 0; i < 4; i++) begin
      e = sb_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_order%0d: got src %h want src %h (pkt %h vs %h)", i, g[116:115], e[116:115], g, e); end
    end
`ifndef TL_ARB_ROUND_ROBIN_EN
    checks++; if (cb != 2) begin errors++; $display("FAIL b2b_idle_gap: got %0d want 2", cb); end
`endif
    ret_d(2'b00, 64'h9, ok); ret_d(2'b00, 64'hA, ok); ret_d(2'b10, 64'hB, ok); ret_d(2'b10, 64'hC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_d_return: got %b want 1", ok); end
  endtask

  task automatic test_reset_mid_grant();
    bit f, ok, seen; int c;
    issue(1, 1'b0, 32'h0000_7000, 64'h7000, 4'd3, 1'b0, 10, f, c);
    got_q.delete();
    u_dn.a_ready = 1'b0;
    set_a(1, 1'b1, 1'b0, 32'h0000_7001, 64'h7001, 4'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = u_dn.a_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_granted: got %b want 1", seen); end
    reset = 1'b1; u_dn.a_ready = 1'b1;
    #1;
    checks++; if (u_dn.a_valid !== 1'b0) begin errors++; $display("FAIL rstmid_a_valid: got %b want 0", u_dn.a_valid); end
    checks++; if (u_r1.a_ready !== 1'b0) begin errors++; $display("FAIL rstmid_r1_a_ready: got %b want 0", u_r1.a_ready); end
    set_a(1, 1'b0, 1'b0, 32'h0000_7001, 64'h7001, 4'd3, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1, 1'b0, 32'h0000_7100, 64'h7100, 4'd3, 1'b0, 10, f, c);
    checks++; if (c != 2 || !f) begin errors++; $display("FAIL rstmid_first_arb: got fired=%b cycles=%0d want 1/2", f, c); end
    issue(1, 1'b0, 32'h0000_7101, 64'h7101, 4'd3, 1'b0, 10, f, c);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL rstmid_counter_cleared: got %b want 1", f); end
    issue(1, 1'b0, 32'h0000_7102, 64'h7102, 4'd3, 1'b0, 8, f, c);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL rstmid_limit: got %b want 0", f); end
    ret_d(2'b10, 64'hD, ok); ret_d(2'b10, 64'hE, ok); ret_d(2'b10, 64'hF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_d_zero_fwd: got %b want 1", ok); end
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_a(0, 1'b0, 1'b0, 32'h0, 64'h0, 4'd0, 1'b0);
    set_a(1, 1'b0, 1'b0, 32'h0, 64'h0, 4'd0, 1'b0);
    u_r0.d_ready = 1'b1; u_r1.d_ready = 1'b1;
    u_dn.a_ready = 1'b1; u_dn.d_valid = 1'b0; u_dn.d_opcode = 3'd1; u_dn.d_param = 2'd0;
    u_dn.d_size = 4'd3; u_dn.d_source = 2'b00; u_dn.d_sink = 1'b0; u_dn.d_denied = 1'b0;
    u_dn.d_data = 64'h0; u_dn.d_corrupt = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_corrupt();
    test_d_routing();
    test_inflight_limit();
    test_same_cycle();
    test_stall();
    test_back_to_back();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
